audio_clip_sequencer: RTL

Plays fixed-length sound clips stored in one shared, single-port sample ROM and streams them into the Audio_Controller write interface. It latches one-cycle play requests from up to four requesters, such as game events. It grants the ROM to one clip at a time by fixed priority and steps the ROM address once per sample period. It also handles the one-cycle ROM read latency and the audio_out_allowed handshake.

---
 rtl/audio_clip_sequencer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/audio_clip_sequencer.sv
// Streams fixed-length clips from a shared single-port sample ROM into the
// Audio_Controller write port, one clip at a time, granted by fixed priority.
module audio_clip_sequencer #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int SAMPLE_DIV = 1042
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic [3:0]            play_req,
    input  logic                  stop,
    input  logic [4*ADDR_W-1:0]   clip_start,
    input  logic [4*ADDR_W-1:0]   clip_end,
    output logic [ADDR_W-1:0]     rom_address,
    input  logic [DATA_W-1:0]     rom_q,
    input  logic                  audio_out_allowed,
    output logic [DATA_W-1:0]     audio_out,
    output logic                  write_audio_out,
    output logic                  busy,
    output logic [1:0]            active_clip,
    output logic                  clip_done,
    output logic                  underrun
);

    localparam int CNT_W = $clog2(SAMPLE_DIV);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_WAIT_OUT,
        S_WAIT_TICK,
        S_ADVANCE
    } state_t;

    state_t            state, next_state;
    logic [CNT_W-1:0]  tick_cnt;
    logic              tick;
    logic [3:0]        pending;
    logic [3:0]        grant_mask;
    logic [1:0]        grant_idx;
    logic              grant;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] end_addr;
    logic              late;
    logic              in_service;

    assign tick = (tick_cnt == CNT_W'(SAMPLE_DIV - 1));

    // Lowest set bit wins; scanning downward lets the last hit be bit 0.
    always_comb begin
        grant_idx = '0;
        for (int i = 3; i >= 0; i--) begin
            if (pending[i]) grant_idx = 2'(i);
        end
    end

    assign grant      = (state == S_IDLE) && (|pending) && !stop;
    assign grant_mask = grant ? (4'b0001 << grant_idx) : 4'b0000;
    assign start_addr = clip_start[grant_idx*ADDR_W +: ADDR_W];
    assign end_addr   = clip_end[active_clip*ADDR_W +: ADDR_W];
    assign in_service = (state == S_FETCH) || (state == S_LATCH) || (state == S_WAIT_OUT);

    assign underrun    = tick && in_service && !stop;
    assign busy        = (state != S_IDLE);
    assign rom_address = addr;

    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        next_state      = state;
        write_audio_out = 1'b0;
        clip_done       = 1'b0;
        case (state)
            S_IDLE:      if (|pending) next_state = S_FETCH;
            S_FETCH:     next_state = S_LATCH;
            S_LATCH:     next_state = S_WAIT_OUT;
            S_WAIT_OUT: begin
                if (audio_out_allowed) begin
                    write_audio_out = 1'b1;
                    // A tick landing on the write cycle counts as late too.
                    next_state = (late || tick) ? S_ADVANCE : S_WAIT_TICK;
                end
            end
            S_WAIT_TICK: if (tick) next_state = S_ADVANCE;
            S_ADVANCE: begin
                if (addr >= end_addr) begin
                    clip_done  = 1'b1;
                    next_state = S_IDLE;
                end else begin
                    next_state = S_FETCH;
                end
            end
            default:     next_state = S_IDLE;
        endcase
        if (stop) begin
            next_state      = S_IDLE;
            write_audio_out = 1'b0;
            clip_done       = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state       <= S_IDLE;
            tick_cnt    <= '0;
            pending     <= '0;
            active_clip <= '0;
            addr        <= '0;
            late        <= 1'b0;
            audio_out   <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state    <= next_state;
            tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);
            pending  <= stop ? 4'b0000 : ((pending & ~grant_mask) | play_req);

            if (grant) begin
                active_clip <= grant_idx;
                addr        <= start_addr;
            end else if (state == S_ADVANCE && next_state == S_FETCH) begin
                addr <= addr + ADDR_W'(1);
            end

            if (stop || (state == S_WAIT_OUT && audio_out_allowed)) late <= 1'b0;
            else if (underrun)                                     late <= 1'b1;

            if (next_state == S_IDLE)  audio_out <= '0;
            else if (state == S_LATCH) audio_out <= rom_q;
        end
    end

endmodule
